// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type and frame-length helpers for the FIFO-fed UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned FRAME_OVERHEAD_BITS = 2;

    function automatic int unsigned frame_bits(input int unsigned width);
        return width + FRAME_OVERHEAD_BITS;
    endfunction

    function automatic int unsigned frame_cycles(input int unsigned width,
                                                 input int unsigned clks_per_bit);
        return frame_bits(width) * clks_per_bit;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// rtl/fifo_uart_tx_baud_tick.sv - bit-period counter, tick marks the last clk of each serial bit
module baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Wrapping on tick makes every bit boundary a fresh count from zero.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter that pops words from an upstream FIFO and serialises 8N1-style frames
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             empty,
    input  logic [WIDTH-1:0] rdata,
    output logic             read,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BIT_W = $clog2(WIDTH) + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    uart_state_e      state_q;
    uart_state_e      state_d;
    logic             tx_q;
    logic             tx_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] shreg_shifted;
    logic [BIT_W-1:0] bit_q;
    logic [BIT_W-1:0] bit_d;
    logic             tick;
    logic             baud_clear;
    logic             frame_end;
    logic             launch;

    // Holding the counter cleared in IDLE aligns the start bit to the launch edge.
    assign baud_clear = (state_q == ST_IDLE);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear),
        .tick  (tick)
    );

    assign frame_end     = (state_q == ST_STOP) && tick;
    assign launch        = !reset && en && !empty && ((state_q == ST_IDLE) || frame_end);
    assign shreg_shifted = shreg_q >> 1;

    assign read = launch;
    assign tx   = tx_q;
    assign busy = !reset && (state_q != ST_IDLE);
    assign done = !reset && frame_end;

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (launch) begin
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    shreg_d = rdata;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d = shreg_shifted;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shreg_shifted[0];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    // Chaining straight into START keeps back-to-back frames gap-free.
                    if (launch) begin
                        state_d = ST_START;
                        tx_d    = 1'b0;
                        shreg_d = rdata;
                        bit_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            shreg_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx in 8-bit/4-clk and 1-bit/2-clk configurations
module tb_fifo_uart_tx;

    logic       clk;
    logic [1:0] reset_v;
    logic [1:0] en_v;
    logic [1:0] empty_v;
    logic [1:0] read_v;
    logic [1:0] tx_v;
    logic [1:0] busy_v;
    logic [1:0] done_v;
    logic [7:0] rdata0;
    logic [0:0] rdata1;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) u0 (
        .clk(clk), .reset(reset_v[0]), .en(en_v[0]), .empty(empty_v[0]), .rdata(rdata0),
        .read(read_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    fifo_uart_tx #(.WIDTH(1), .CLKS_PER_BIT(2)) u1 (
        .clk(clk), .reset(reset_v[1]), .en(en_v[1]), .empty(empty_v[1]), .rdata(rdata1),
        .read(read_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int cyc;

    // Upstream FIFO contents and expected serial waveform, one set per instance.
    logic [15:0] fifo_mem [0:1][0:1023];
    int          f_wr [0:1];
    int          f_rd [0:1];
    logic        e_tx [0:1][0:63];
    logic        e_dn [0:1][0:63];
    int          e_rd [0:1];
    int          e_n  [0:1];
    logic        prev_rst  [0:1];
    logic        last_read [0:1];
    logic        last_tx   [0:1];
    logic        last_done [0:1];
    logic        last_busy [0:1];

    typedef struct {
        int          inst;
        logic [15:0] word;
        logic [17:0] bits;
        int          len;
    } vec_t;

    vec_t vecs [0:5];

    function automatic int wbits(input int i);
        return (i == 0) ? 8 : 1;
    endfunction

    function automatic int cpb(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_word(input int i, input logic [15:0] w);
        fifo_mem[i][f_wr[i]] = w;
        f_wr[i]++;
    endtask

    task automatic e_push(input int i, input logic t, input logic d);
        int idx;
        idx = (e_rd[i] + e_n[i]) % 64;
        e_tx[i][idx] = t;
        e_dn[i][idx] = d;
        e_n[i]++;
    endtask

    // A frame is C low cycles, then each data bit LSB first for C cycles, then C high cycles.
    task automatic push_frame(input int i, input logic [15:0] w);
        int nb;
        int c;
        nb = wbits(i);
        c  = cpb(i);
        for (int k = 0; k < c; k++) e_push(i, 1'b0, 1'b0);
        for (int b = 0; b < nb; b++)
            for (int k = 0; k < c; k++) e_push(i, w[b], 1'b0);
        for (int k = 0; k < c; k++) e_push(i, 1'b1, k == c - 1);
    endtask

    task automatic model_check(input int i);
        logic exp_read;
        if (reset_v[i]) begin
            check($sformatf("u%0d.rst_read", i), 32'(read_v[i]), 32'd0);
            check($sformatf("u%0d.rst_busy", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("u%0d.rst_done", i), 32'(done_v[i]), 32'd0);
            if (prev_rst[i]) check($sformatf("u%0d.rst_tx", i), 32'(tx_v[i]), 32'd1);
            e_n[i] = 0;
        end else begin
            exp_read = en_v[i] && !empty_v[i] && (e_n[i] == 0 || e_dn[i][e_rd[i]]);
            check($sformatf("u%0d.read", i), 32'(read_v[i]), 32'(exp_read));
            if (e_n[i] > 0) begin
                check($sformatf("u%0d.tx", i),   32'(tx_v[i]),   32'(e_tx[i][e_rd[i]]));
                check($sformatf("u%0d.busy", i), 32'(busy_v[i]), 32'd1);
                check($sformatf("u%0d.done", i), 32'(done_v[i]), 32'(e_dn[i][e_rd[i]]));
                e_rd[i] = (e_rd[i] + 1) % 64;
                e_n[i]--;
            end else begin
                check($sformatf("u%0d.tx_idle", i),   32'(tx_v[i]),   32'd1);
                check($sformatf("u%0d.busy_idle", i), 32'(busy_v[i]), 32'd0);
                check($sformatf("u%0d.done_idle", i), 32'(done_v[i]), 32'd0);
            end
            if (exp_read) push_frame(i, fifo_mem[i][f_rd[i]]);
        end
        prev_rst[i]  = reset_v[i];
        last_read[i] = read_v[i];
        last_tx[i]   = tx_v[i];
        last_done[i] = done_v[i];
        last_busy[i] = busy_v[i];
    endtask

    task automatic cycle();
        for (int i = 0; i < 2; i++) empty_v[i] = (f_rd[i] == f_wr[i]);
        rdata0 = empty_v[0] ? 8'($urandom) : fifo_mem[0][f_rd[0]][7:0];
        rdata1 = empty_v[1] ? 1'($urandom) : fifo_mem[1][f_rd[1]][0:0];
        @(negedge clk);
        for (int i = 0; i < 2; i++) model_check(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            if (last_read[i] && f_rd[i] < f_wr[i]) f_rd[i]++;
        cyc++;
    endtask

    task automatic wait_read(input int i, input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cycle();
            got = last_read[i];
        end
        check(name, 32'(got), 32'd1);
    endtask

    initial begin
        int saved;
        int nrd, ndn, rd1, rd2, dn1, dn2;
        int guard;
        int pushed1;
        int start0, start1;
        logic fin;

        total = 0; bad = 0; cyc = 0;
        for (int i = 0; i < 2; i++) begin
            f_wr[i] = 0; f_rd[i] = 0; e_rd[i] = 0; e_n[i] = 0;
            prev_rst[i] = 1'b0; last_read[i] = 1'b0; last_tx[i] = 1'b1;
            last_done[i] = 1'b0; last_busy[i] = 1'b0;
        end
        empty_v = 2'b11; rdata0 = '0; rdata1 = '0;

        vecs[0] = '{0, 16'h00A5, 18'b1101001010, 40};
        vecs[1] = '{0, 16'h0001, 18'b1000000010, 40};
        vecs[2] = '{0, 16'h00FF, 18'b1111111110, 40};
        vecs[3] = '{0, 16'h003C, 18'b1001111000, 40};
        vecs[4] = '{1, 16'h0001, 18'b110, 6};
        vecs[5] = '{1, 16'h0000, 18'b100, 6};

        // Reset held with data waiting; launch expected on the first free cycle.
        reset_v = 2'b11;
        en_v    = 2'b11;
        push_word(0, 16'h0011);
        push_word(1, 16'h0001);
        repeat (3) cycle();
        reset_v = 2'b00;
        cycle();
        check("launch_after_reset_u0", 32'(last_read[0]), 32'd1);
        check("launch_after_reset_u1", 32'(last_read[1]), 32'd1);
        en_v = 2'b00;
        repeat (45) cycle();

        for (int v = 0; v < 6; v++) begin
            int inst;
            inst = vecs[v].inst;
            en_v = 2'b00;
            en_v[inst] = 1'b1;
            push_word(inst, vecs[v].word);
            wait_read(inst, $sformatf("vec%0d.launch", v));
            en_v = 2'b00;
            for (int k = 0; k < vecs[v].len; k++) begin
                cycle();
                check($sformatf("vec%0d.tx[%0d]", v, k), 32'(last_tx[inst]),
                      32'(vecs[v].bits[k / cpb(inst)]));
                check($sformatf("vec%0d.done[%0d]", v, k), 32'(last_done[inst]),
                      32'(k == vecs[v].len - 1));
            end
            cycle();
            check($sformatf("vec%0d.busy_after", v), 32'(last_busy[inst]), 32'd0);
        end

        // Back-to-back: second pop lands in the first stop's last cycle.
        en_v = 2'b01;
        push_word(0, 16'h0001);
        push_word(0, 16'h00FF);
        nrd = 0; ndn = 0; rd1 = 0; rd2 = 0; dn1 = 0; dn2 = 0;
        for (int k = 0; k < 120; k++) begin
            cycle();
            if (last_read[0]) begin
                if (nrd == 0) rd1 = k; else rd2 = k;
                nrd++;
            end
            if (last_done[0]) begin
                if (ndn == 0) dn1 = k; else dn2 = k;
                ndn++;
            end
        end
        en_v = 2'b00;
        check("b2b.reads", 32'(nrd), 32'd2);
        check("b2b.dones", 32'(ndn), 32'd2);
        check("b2b.read_at_done", 32'(rd2), 32'(dn1));
        check("b2b.total_cycles", 32'(dn2 - rd1), 32'd80);

        // Gating by empty and en.
        en_v = 2'b11;
        repeat (100) cycle();
        en_v = 2'b00;
        saved = f_rd[0];
        push_word(0, 16'h005A);
        repeat (20) cycle();
        check("en_low.no_pop", 32'(f_rd[0] - saved), 32'd0);
        push_word(0, 16'h0077);
        en_v[0] = 1'b1;
        wait_read(0, "en_high.launch");
        repeat (5) cycle();
        en_v[0] = 1'b0;
        repeat (60) cycle();
        check("en_drop.one_pop", 32'(f_rd[0] - saved), 32'd1);
        en_v[0] = 1'b1;
        repeat (50) cycle();
        en_v[0] = 1'b0;

        // Reset during data bit 3 of 0x3C; the next word must start right after.
        push_word(0, 16'h003C);
        push_word(0, 16'h005A);
        en_v[0] = 1'b1;
        wait_read(0, "rst_mid.launch");
        repeat (17) cycle();
        reset_v[0] = 1'b1;
        cycle();
        reset_v[0] = 1'b0;
        cycle();
        check("rst_mid.tx_high", 32'(last_tx[0]), 32'd1);
        check("rst_mid.idle", 32'(last_busy[0]), 32'd0);
        check("rst_mid.relaunch", 32'(last_read[0]), 32'd1);
        check("rst_mid.new_word", 32'(fifo_mem[0][f_rd[0] - 1]), 32'h5A);
        en_v[0] = 1'b0;
        repeat (45) cycle();

        // Random streams: full FIFO on the 8-bit instance, trickle feed on the 1-bit one.
        start0 = f_rd[0];
        start1 = f_rd[1];
        for (int k = 0; k < 256; k++) push_word(0, 16'($urandom_range(0, 255)));
        pushed1 = 0;
        fin = 1'b0;
        guard = 0;
        while (!fin && guard < 30000) begin
            en_v[0] = ($urandom % 8) != 0;
            en_v[1] = ($urandom % 8) != 0;
            if (pushed1 < 256 && ($urandom % 8) == 0) begin
                push_word(1, 16'($urandom_range(0, 1)));
                pushed1++;
            end
            cycle();
            guard++;
            fin = (pushed1 == 256) && (f_rd[0] == f_wr[0]) && (f_rd[1] == f_wr[1])
                  && (e_n[0] == 0) && (e_n[1] == 0);
        end
        en_v = 2'b00;
        check("rand.finished", 32'(fin), 32'd1);
        check("rand.pops_u0", 32'(f_rd[0] - start0), 32'd256);
        check("rand.pops_u1", 32'(f_rd[1] - start1), 32'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame (1..16).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, clk cycles per serial bit (2..65535).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  permits starting a new frame; does not affect a frame in progress.
REQ-006 SHALL have port empty  input  1  upstream FIFO empty flag.
REQ-007 SHALL have port rdata  input  WIDTH  FIFO head word, combinationally valid whenever empty is low.
REQ-008 SHALL have port read  output  1  one-cycle pop strobe to the FIFO read input.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high from the cycle after a pop until the frame's last stop cycle, inclusive.
REQ-011 SHALL have port done  output  1  one-cycle pulse in the last cycle of each stop bit.

Function
REQ-012 SHALL implement states IDLE, START, DATA, STOP.
REQ-013 SHALL define launch = en & !empty & (state==IDLE | last cycle of STOP).
REQ-014 SHALL drive read = launch combinationally; read never high while empty is high.
REQ-015 SHALL, on a launch cycle, capture rdata into a WIDTH-bit shift register and enter START next cycle.
REQ-016 SHALL hold tx low for exactly CLKS_PER_BIT cycles in START, then enter DATA.
REQ-017 SHALL in DATA send WIDTH bits LSB first, each held CLKS_PER_BIT cycles, shift register moving right once per bit.
REQ-018 SHALL track the bit index with a counter of width clog2(WIDTH)+1; DATA exits to STOP after bit WIDTH-1.
REQ-019 SHALL hold tx high for CLKS_PER_BIT cycles in STOP; exit to START if launch, else IDLE.
REQ-020 SHALL produce frames of exactly (WIDTH+2)*CLKS_PER_BIT cycles; back-to-back frames have no idle gap.
REQ-021 SHALL drive tx high in IDLE; tx SHALL be a registered output (glitch-free).
REQ-022 SHALL count baud cycles with a counter of width clog2(CLKS_PER_BIT), cleared at every state entry and every bit boundary.
REQ-023 SHALL ignore en deassertion mid-frame; the frame completes and no new launch occurs while en is low.
REQ-024 SHALL ignore rdata and empty changes outside launch cycles.
REQ-025 SHALL pop exactly one word per frame; no word is dropped or duplicated.

Reset
REQ-026 SHALL, while reset is high at a posedge, set state=IDLE, tx=1, shift register=0, counters=0.
REQ-027 SHALL force read=0, busy=0, done=0 during any cycle reset is high.
REQ-028 SHALL abort any frame on reset mid-operation; tx high from the next cycle; the aborted word is lost (not re-popped).
REQ-029 SHALL allow a launch in the first cycle after reset deasserts if en & !empty.

Structure
REQ-030 SHALL place the state enum type and frame-length helper constants in shared package uart_pkg.
REQ-031 SHALL use one sub-module baud_tick (parameter CLKS_PER_BIT; inputs clk, reset, clear; output tick on last cycle of each bit period).
REQ-032 SHALL keep next-state/launch logic combinational and all registers in a single clocked process.

Verification
REQ-033 SHALL verify reset: reset high 3 cycles with empty=0, en=1 -> read=0, tx=1, busy=0 throughout; launch on first cycle after release.
REQ-034 SHALL verify single frame: WIDTH=8, CLKS_PER_BIT=4, rdata=0xA5 -> read one cycle; tx = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles, 40 cycles total; done pulses once at cycle 40.
REQ-035 SHALL verify back-to-back: FIFO holds 0x01, 0xFF -> second read coincides with first done; second start bit begins next cycle; 80 cycles total, no idle gap.
REQ-036 SHALL verify empty/en gating: empty=1 for 100 cycles -> read=0, tx=1; en=0 with empty=0 -> no pop; en dropped mid-frame -> frame completes, no further pop.
REQ-037 SHALL verify reset mid-frame: reset at DATA bit 3 of 0x3C -> tx=1 next cycle, state IDLE, next frame starts with new head word.
REQ-038 SHALL verify parameter edges: WIDTH=1, CLKS_PER_BIT=2 -> 6-cycle frames; random stream of 256 words through a FIFO -> received sequence equals sent sequence.
